// File: rtl/popcount_pkg.sv
// popcount_pkg: shared FSM state type and arithmetic helpers for the popcount accumulator
package popcount_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  // Returns {overflow, value}; value is clamped to 2^w-1 (w <= 32)
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
    logic [32:0] s, m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? {1'b1, m[31:0]} : {1'b0, s[31:0]};
  endfunction
endpackage

// File: rtl/popcount_comb.sv
// popcount_comb: combinational population count of a WIDTH-bit word
module popcount_comb #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) cnt_o = cnt_o + CNT_W'(data_i[i]);
  end
endmodule

// File: rtl/popcount_accum.sv
// popcount_accum: per-word popcount plus saturating per-frame total over valid/ready; POPCOUNT_ONEHOT_EN adds word_onehot
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             word_valid,
  output logic [CNT_W-1:0] word_cnt,
`ifdef POPCOUNT_ONEHOT_EN
  output logic [WIDTH:0]   word_onehot,
`endif
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum_data,
  output logic             sum_ovf
);
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic [CNT_W-1:0] word_cnt_q;
  logic word_valid_q;
  logic [CNT_W-1:0] cnt;
  logic [32:0] sum_w;
  logic accept, consume;
  popcount_comb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (.data_i(in_data), .cnt_o(cnt));
  assign in_ready   = (state_q != HOLD);
  assign sum_valid  = (state_q == HOLD);
  assign sum_data   = sum_valid ? acc_q : '0;
  assign sum_ovf    = sum_valid & ovf_q;
  assign word_cnt   = word_cnt_q;
  assign word_valid = word_valid_q;
  always_comb begin
    accept  = in_valid & in_ready;
    consume = sum_valid & sum_ready;
    sum_w   = sat_add(32'(acc_q), 32'(cnt), ACC_W);
    state_d = consume ? IDLE : accept ? (in_last ? HOLD : ACCUM) : state_q;
    acc_d   = consume ? '0 : accept ? ACC_W'(sum_w[31:0]) : acc_q;
    ovf_d   = consume ? 1'b0 : accept ? (ovf_q | sum_w[32]) : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      word_cnt_q   <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      word_valid_q <= accept;
      if (accept) word_cnt_q <= cnt;
    end
  end
`ifdef POPCOUNT_ONEHOT_EN
  logic [WIDTH:0] onehot_q;
  assign word_onehot = onehot_q;
  always_ff @(posedge clk) begin
    if (rst) onehot_q <= (WIDTH+1)'(1);
    else if (accept) onehot_q <= (WIDTH+1)'(1) << cnt;
  end
`endif
endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: directed checks on an ACC_W=8 and an ACC_W=4 instance driven by the same stream
module tb_popcount_accum;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, sum_ready = 1;
  logic [3:0] in_data = '0;
  logic rdy8, wv8, sv8, ov8, rdy4, wv4, sv4, ov4;
  logic [2:0] wc8, wc4;
  logic [7:0] sd8;
  logic [3:0] sd4;
`ifdef POPCOUNT_ONEHOT_EN
  logic [4:0] oh8, oh4;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  popcount_accum #(.WIDTH(4), .ACC_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data),
    .in_last(in_last), .word_valid(wv8), .word_cnt(wc8),
`ifdef POPCOUNT_ONEHOT_EN
    .word_onehot(oh8),
`endif
    .sum_valid(sv8), .sum_ready(sum_ready), .sum_data(sd8), .sum_ovf(ov8));
  popcount_accum #(.WIDTH(4), .ACC_W(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .in_last(in_last), .word_valid(wv4), .word_cnt(wc4),
`ifdef POPCOUNT_ONEHOT_EN
    .word_onehot(oh4),
`endif
    .sum_valid(sv4), .sum_ready(sum_ready), .sum_data(sd4), .sum_ovf(ov4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [3:0] d, input logic l);
    in_valid = 1; in_data = d; in_last = l;
    tick();
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_ready", rdy8, 1); chk("rst_wv", wv8, 0); chk("rst_wc", wc8, 0);
    chk("rst_sv", sv8, 0); chk("rst_sd", sd8, 0); chk("rst_ovf", ov8, 0);
`ifdef POPCOUNT_ONEHOT_EN
    chk("rst_oh", oh8, 5'b00001);
`endif
    in_last = 1; tick();
    chk("last_no_valid_sv", sv8, 0); chk("last_no_valid_rdy", rdy8, 1);
    beat(4'b1011, 0);
    chk("f1_wv0", wv8, 1); chk("f1_wc0", wc8, 3); chk("f1_sv0", sv8, 0);
`ifdef POPCOUNT_ONEHOT_EN
    chk("f1_oh0", oh8, 5'b01000);
`endif
    beat(4'b0000, 0);
    chk("f1_wv1", wv8, 1); chk("f1_wc1", wc8, 0);
    sum_ready = 0;
    beat(4'b1111, 1);
    chk("f1_wc2", wc8, 4); chk("f1_sv", sv8, 1); chk("f1_sd8", sd8, 7);
    chk("f1_sd4", sd4, 7); chk("f1_ovf", ov8, 0); chk("f1_rdy", rdy8, 0);
`ifdef POPCOUNT_ONEHOT_EN
    chk("f1_oh2", oh8, 5'b10000);
`endif
    in_data = 4'b0001; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rdy", rdy8, 0); chk("bp_sv", sv8, 1); chk("bp_sd", sd8, 7); chk("bp_wv", wv8, 0);
    end
    sum_ready = 1; tick();
    chk("consume_sv", sv8, 0); chk("consume_rdy", rdy8, 1); chk("bubble_wv", wv8, 0);
    tick();
    chk("post_bubble_wv", wv8, 1); chk("post_bubble_wc", wc8, 1); chk("post_bubble_sd", sd8, 1);
    in_valid = 0; tick();
    chk("consume2_sv", sv8, 0);
    for (int i = 0; i < 5; i++) beat(4'b1111, i == 4);
    chk("sat_sv", sv4, 1); chk("sat_sd4", sd4, 15); chk("sat_ovf4", ov4, 1);
    chk("nosat_sd8", sd8, 20); chk("nosat_ovf8", ov8, 0);
    in_valid = 0; tick();
    beat(4'b0001, 1);
    chk("after_sat_sd4", sd4, 1); chk("after_sat_ovf4", ov4, 0);
    in_valid = 0; tick();
    beat(4'b0110, 1);
    chk("single_sv", sv8, 1); chk("single_sd", sd8, 2); chk("single_wc", wc8, 2);
    in_data = 4'b1101; tick();
    chk("single_consume_wv", wv8, 0); chk("single_consume_sv", sv8, 0);
    tick();
    chk("single2_sd", sd8, 3); chk("single2_ovf", ov8, 0);
    in_valid = 0; tick();
    beat(4'b0111, 0);
    beat(4'b0001, 0);
    in_valid = 0; rst = 1; tick(); rst = 0;
    chk("midrst_sv", sv8, 0); chk("midrst_wv", wv8, 0); chk("midrst_wc", wc8, 0);
`ifdef POPCOUNT_ONEHOT_EN
    chk("midrst_oh", oh8, 5'b00001);
`endif
    beat(4'b0001, 1);
    chk("midrst_sd8", sd8, 1); chk("midrst_sd4", sd4, 1);
    in_valid = 0; tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
